// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_frame_arbiter
//  Purpose  : Frame-atomic arbiter in front of the 32-bit source side of the
//             Ethernet TX AXIS buffer. Shares the buffer between the uDMA TX
//             channel (src0) and the control/pause-frame generator (src1).
//             Only whole frames are granted, oversize frames are truncated and
//             flagged, and an idle gap is inserted after every frame.
//  Ports    : clk_i, rst_i        clock / synchronous active-high reset
//             cfg_en_i            allows new grants (sampled in IDLE only)
//             s0_axis_*, s1_axis_* source streams (tdata, byte_count, tvalid,
//                                 tlast, tuser in; tready out)
//             m_axis_*            stream to the TX buffer
//             busy_o              state != IDLE
//             frame_done_o        pulse on every forwarded tlast handshake
//             frame_src_o         source of the current / last granted frame
//             err_oversize_o      pulse when a frame is truncated
//  Revision : 1.0  initial release
// ============================================================================
module eth_tx_frame_arbiter #(
  parameter int MAX_WORDS = 384,   // 2..4095, includes the last word
  parameter int IFG_WORDS = 3,     // idle cycles after each frame, 0 = none
  parameter int PRIO_SRC1 = 1      // 1: src1 strict priority, 0: round-robin
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,

  input  logic [31:0] s0_axis_tdata,
  input  logic [1:0]  s0_axis_byte_count,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,
  output logic        s0_axis_tready,

  input  logic [31:0] s1_axis_tdata,
  input  logic [1:0]  s1_axis_byte_count,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,
  output logic        s1_axis_tready,

  output logic [31:0] m_axis_tdata,
  output logic [1:0]  m_axis_byte_count,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,

  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_src_o,
  output logic        err_oversize_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Where a frame goes once its last word has been consumed.
  localparam logic [1:0] ST_AFTER = (IFG_WORDS > 0) ? ST_GAP : ST_IDLE;

  localparam int         CNT_W     = 12;
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(MAX_WORDS - 1);

  localparam int         GAP_W    = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_WORDS > 0) ? IFG_WORDS - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             frame_src_q, frame_src_d;

  logic [31:0]      sel_tdata;
  logic [1:0]       sel_byte_count;
  logic             sel_tvalid;
  logic             sel_tlast;
  logic             sel_tuser;
  logic             at_max;
  logic             truncate;
  logic             grant_src;

  // The granted source drives the datapath for the whole frame.
  assign sel_tdata      = frame_src_q ? s1_axis_tdata      : s0_axis_tdata;
  assign sel_byte_count = frame_src_q ? s1_axis_byte_count : s0_axis_byte_count;
  assign sel_tvalid     = frame_src_q ? s1_axis_tvalid     : s0_axis_tvalid;
  assign sel_tlast      = frame_src_q ? s1_axis_tlast      : s0_axis_tlast;
  assign sel_tuser      = frame_src_q ? s1_axis_tuser      : s0_axis_tuser;

  // The word at index MAX_WORDS-1 must close the frame; if the source did
  // not mark it as last, the arbiter closes it and flags an error.
  assign at_max   = (word_cnt_q == WORD_LAST);
  assign truncate = at_max & ~sel_tlast;

  assign busy_o      = (state_q != ST_IDLE);
  assign frame_src_o = frame_src_q;

  always_comb begin
    grant_src = s1_axis_tvalid;
    if (PRIO_SRC1 == 0) begin
      // Round-robin only matters on contention; otherwise take whoever asks.
      if (s0_axis_tvalid && s1_axis_tvalid) begin
        grant_src = ~last_grant_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    frame_src_d  = frame_src_q;

    m_axis_tdata      = 32'h0;
    m_axis_byte_count = 2'h0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    m_axis_tuser      = 1'b0;
    s0_axis_tready    = 1'b0;
    s1_axis_tready    = 1'b0;
    frame_done_o      = 1'b0;
    err_oversize_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_en_i && (s0_axis_tvalid || s1_axis_tvalid)) begin
          state_d      = ST_XFER;
          word_cnt_d   = '0;
          last_grant_d = grant_src;
          frame_src_d  = grant_src;
        end
      end

      ST_XFER: begin
        m_axis_tdata      = sel_tdata;
        m_axis_tvalid     = sel_tvalid;
        m_axis_tlast      = sel_tlast | at_max;
        m_axis_tuser      = sel_tuser | truncate;
        // byte_count is only meaningful on the source's own last word; a
        // truncated last word is reported as fully populated.
        m_axis_byte_count = sel_tlast ? sel_byte_count : 2'h3;
        s0_axis_tready    = ~frame_src_q & m_axis_tready;
        s1_axis_tready    =  frame_src_q & m_axis_tready;

        if (sel_tvalid && m_axis_tready) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (sel_tlast || at_max) begin
            frame_done_o = 1'b1;
            gap_cnt_d    = '0;
            if (truncate) begin
              err_oversize_o = 1'b1;
              state_d        = ST_DROP;
            end else begin
              state_d = ST_AFTER;
            end
          end
        end
      end

      ST_DROP: begin
        // Swallow the remainder of the oversize frame without forwarding.
        s0_axis_tready = ~frame_src_q;
        s1_axis_tready =  frame_src_q;
        if (sel_tvalid && sel_tlast) begin
          gap_cnt_d = '0;
          state_d   = ST_AFTER;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      frame_src_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      frame_src_q  <= frame_src_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_tx_frame_arbiter
//  Purpose  : Self-checking bench for eth_tx_frame_arbiter. Two instances:
//             u0 (MAX_WORDS=384, IFG_WORDS=3, PRIO_SRC1=1) and
//             u1 (MAX_WORDS=4,   IFG_WORDS=3, PRIO_SRC1=0).
//             Expected words are queued per source when a frame is planned and
//             popped when the DUT hands a word to the TX buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_tx_frame_arbiter;

  localparam int BUDGET = 300;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  bc;
    logic        l;
    logic        u;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en [2];
  logic [31:0] sd  [2][2];
  logic [1:0]  sbc [2][2];
  logic        sv  [2][2];
  logic        sl  [2][2];
  logic        su  [2][2];
  logic        sr  [2][2];
  logic [31:0] md  [2];
  logic [1:0]  mbc [2];
  logic        mv [2], ml [2], mu [2], mr [2];
  logic        busy [2], done [2], fsrc [2], err [2];

  int total = 0;
  int bad   = 0;
  int done_cnt [2];
  int err_cnt  [2];

  exp_t q00 [$];
  exp_t q01 [$];
  exp_t q10 [$];
  exp_t q11 [$];
  logic ord0 [$];
  logic ord1 [$];

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(.MAX_WORDS(384), .IFG_WORDS(3), .PRIO_SRC1(1)) u0 (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en[0]),
    .s0_axis_tdata(sd[0][0]), .s0_axis_byte_count(sbc[0][0]), .s0_axis_tvalid(sv[0][0]),
    .s0_axis_tlast(sl[0][0]), .s0_axis_tuser(su[0][0]), .s0_axis_tready(sr[0][0]),
    .s1_axis_tdata(sd[0][1]), .s1_axis_byte_count(sbc[0][1]), .s1_axis_tvalid(sv[0][1]),
    .s1_axis_tlast(sl[0][1]), .s1_axis_tuser(su[0][1]), .s1_axis_tready(sr[0][1]),
    .m_axis_tdata(md[0]), .m_axis_byte_count(mbc[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tlast(ml[0]), .m_axis_tuser(mu[0]), .m_axis_tready(mr[0]),
    .busy_o(busy[0]), .frame_done_o(done[0]), .frame_src_o(fsrc[0]), .err_oversize_o(err[0])
  );

  eth_tx_frame_arbiter #(.MAX_WORDS(4), .IFG_WORDS(3), .PRIO_SRC1(0)) u1 (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en[1]),
    .s0_axis_tdata(sd[1][0]), .s0_axis_byte_count(sbc[1][0]), .s0_axis_tvalid(sv[1][0]),
    .s0_axis_tlast(sl[1][0]), .s0_axis_tuser(su[1][0]), .s0_axis_tready(sr[1][0]),
    .s1_axis_tdata(sd[1][1]), .s1_axis_byte_count(sbc[1][1]), .s1_axis_tvalid(sv[1][1]),
    .s1_axis_tlast(sl[1][1]), .s1_axis_tuser(su[1][1]), .s1_axis_tready(sr[1][1]),
    .m_axis_tdata(md[1]), .m_axis_byte_count(mbc[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tlast(ml[1]), .m_axis_tuser(mu[1]), .m_axis_tready(mr[1]),
    .busy_o(busy[1]), .frame_done_o(done[1]), .frame_src_o(fsrc[1]), .err_oversize_o(err[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int i, input int s, input int fid, input int w);
    return {4'(i), 4'(s), 8'(fid), 16'(w)};
  endfunction

  task automatic push_word(input int k, input exp_t e);
    case (k)
      0: q00.push_back(e);
      1: q01.push_back(e);
      2: q10.push_back(e);
      default: q11.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q00.size();
      1: return q01.size();
      2: return q10.size();
      default: return q11.size();
    endcase
  endfunction

  task automatic pop_word(input int k, output exp_t e, output bit ok);
    e  = '0;
    ok = (qsize(k) > 0);
    if (ok) begin
      case (k)
        0: e = q00.pop_front();
        1: e = q01.pop_front();
        2: e = q10.pop_front();
        default: e = q11.pop_front();
      endcase
    end
  endtask

  // Expected output of one frame, with truncation at max words.
  task automatic push_frame(input int i, input int s, input int fid, input int n,
                            input logic [1:0] bc, input logic user, input int max);
    exp_t e;
    for (int w = 0; w < n && w < max; w++) begin
      e.d  = mk_data(i, s, fid, w);
      e.l  = (w == n - 1) || (w == max - 1);
      e.u  = user | ((w == max - 1) && (w != n - 1));
      e.bc = (w == n - 1) ? bc : 2'd3;
      push_word(i * 2 + s, e);
    end
  endtask

  // Drives words 0..nstop-1 of an n-word frame; returns with the last driven
  // word still presented (1 time unit after the edge that accepted it).
  task automatic drive_frame(input int i, input int s, input int fid, input int n, input int nstop,
                             input logic [1:0] bc, input logic user, input bit bub,
                             output int first_wait);
    int waited;
    bit hs;
    first_wait = 0;
    for (int w = 0; w < nstop; w++) begin
      if (bub && (w % 2 == 1)) begin
        sv[i][s] = 1'b0;
        @(posedge clk); #1;
      end
      sd[i][s]  = mk_data(i, s, fid, w);
      sl[i][s]  = (w == n - 1);
      sbc[i][s] = (w == n - 1) ? bc : 2'($urandom_range(0, 3));
      su[i][s]  = user;
      sv[i][s]  = 1'b1;
      waited = 0;
      hs     = 1'b0;
      while (!hs && waited < BUDGET) begin
        @(negedge clk);
        hs = sr[i][s];
        @(posedge clk); #1;
        waited++;
      end
      if (!hs) chk("drv_timeout", 64'(0), 64'(1));
      if (w == 0) first_wait = waited;
    end
  endtask

  task automatic src_idle(input int i, input int s);
    sv[i][s] = 1'b0;
    sl[i][s] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit   ok;
    int   k;
    if (!rst) begin
      if (done[i]) begin
        done_cnt[i]++;
        if (i == 0) ord0.push_back(fsrc[i]);
        else        ord1.push_back(fsrc[i]);
      end
      if (err[i]) err_cnt[i]++;
      if (mv[i] && mr[i]) begin
        k = i * 2 + int'(fsrc[i]);
        pop_word(k, e, ok);
        chk("m_word_expected", 64'(ok), 64'(1));
        if (ok) begin
          chk("m_tdata", 64'(md[i]), 64'(e.d));
          chk("m_byte_count", 64'(mbc[i]), 64'(e.bc));
          chk("m_tlast", 64'(ml[i]), 64'(e.l));
          chk("m_tuser", 64'(mu[i]), 64'(e.u));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fw, fw0, fw1;
    logic o;
    exp_t e;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cfg_en[i] = 1'b0;
      mr[i]     = 1'b1;
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
      for (int s = 0; s < 2; s++) begin
        sd[i][s] = '0; sbc[i][s] = '0; sv[i][s] = 1'b0; sl[i][s] = 1'b0; su[i][s] = 1'b0;
      end
    end
    wait_cycles(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'(0));
      chk("rst_m_tvalid", 64'(mv[i]), 64'(0));
      chk("rst_s0_tready", 64'(sr[i][0]), 64'(0));
      chk("rst_s1_tready", 64'(sr[i][1]), 64'(0));
      chk("rst_frame_src", 64'(fsrc[i]), 64'(0));
      chk("rst_frame_done", 64'(done[i]), 64'(0));
      chk("rst_err", 64'(err[i]), 64'(0));
    end
    @(posedge clk); #1;

    // T1: src0 3-word frame, last byte_count=1, then 3 gap cycles
    cfg_en[0] = 1'b1;
    ord0.delete();
    push_frame(0, 0, 1, 3, 2'd1, 1'b0, 384);
    drive_frame(0, 0, 1, 3, 3, 2'd1, 1'b0, 1'b0, fw);
    src_idle(0, 0);
    chk("t1_first_word_edge", 64'(fw), 64'(2));
    chk("t1_done_cnt", 64'(done_cnt[0]), 64'(1));
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("t1_gap_busy", 64'(busy[0]), 64'(1));
      chk("t1_gap_tvalid", 64'(mv[0]), 64'(0));
    end
    @(negedge clk);
    chk("t1_idle_after_gap", 64'(busy[0]), 64'(0));
    @(posedge clk); #1;
    chk("t1_err_cnt", 64'(err_cnt[0]), 64'(0));
    chk("t1_queue_empty", 64'(qsize(0)), 64'(0));

    // T2: round-robin with both sources continuously valid
    cfg_en[1] = 1'b1;
    done_cnt[1] = 0;
    ord1.delete();
    for (int f = 1; f <= 3; f++) begin
      push_frame(1, 0, f, 2, 2'd2, 1'b0, 4);
      push_frame(1, 1, f, 2, 2'd2, 1'b0, 4);
    end
    fork
      begin
        for (int f = 1; f <= 3; f++) drive_frame(1, 0, f, 2, 2, 2'd2, 1'b0, 1'b0, fw0);
        src_idle(1, 0);
      end
      begin
        for (int f = 1; f <= 3; f++) drive_frame(1, 1, f, 2, 2, 2'd2, 1'b0, 1'b0, fw1);
        src_idle(1, 1);
      end
    join
    wait_cycles(8);
    chk("t2_done_cnt", 64'(done_cnt[1]), 64'(6));
    for (int j = 0; j < 6; j++) begin
      o = (ord1.size() > 0) ? ord1.pop_front() : 1'bx;
      chk("t2_grant_order", 64'(o), 64'(j % 2));
    end
    chk("t2_q_src0_empty", 64'(qsize(2)), 64'(0));
    chk("t2_q_src1_empty", 64'(qsize(3)), 64'(0));

    // T3: src1 arrives during a src0 frame; src0 finishes, src1 next
    ord0.delete();
    push_frame(0, 0, 2, 4, 2'd3, 1'b0, 384);
    push_frame(0, 1, 1, 2, 2'd0, 1'b0, 384);
    fork
      begin
        drive_frame(0, 0, 2, 4, 4, 2'd3, 1'b0, 1'b0, fw0);
        src_idle(0, 0);
      end
      begin
        wait_cycles(2);
        drive_frame(0, 1, 1, 2, 2, 2'd0, 1'b0, 1'b0, fw1);
        src_idle(0, 1);
      end
    join
    wait_cycles(6);
    o = (ord0.size() > 0) ? ord0.pop_front() : 1'bx;
    chk("t3_first_grant", 64'(o), 64'(0));
    o = (ord0.size() > 0) ? ord0.pop_front() : 1'bx;
    chk("t3_second_grant", 64'(o), 64'(1));

    // T3b: simultaneous request with last grant = src1 -> strict priority still src1
    ord0.delete();
    push_frame(0, 0, 3, 2, 2'd1, 1'b0, 384);
    push_frame(0, 1, 2, 2, 2'd2, 1'b0, 384);
    fork
      begin
        drive_frame(0, 0, 3, 2, 2, 2'd1, 1'b0, 1'b0, fw0);
        src_idle(0, 0);
      end
      begin
        drive_frame(0, 1, 2, 2, 2, 2'd2, 1'b0, 1'b0, fw1);
        src_idle(0, 1);
      end
    join
    wait_cycles(6);
    o = (ord0.size() > 0) ? ord0.pop_front() : 1'bx;
    chk("t3b_first_grant", 64'(o), 64'(1));
    o = (ord0.size() > 0) ? ord0.pop_front() : 1'bx;
    chk("t3b_second_grant", 64'(o), 64'(0));

    // T4: MAX_WORDS=4, 6-word frame truncated; then exact 4-word frame is clean
    err_cnt[1]  = 0;
    done_cnt[1] = 0;
    push_frame(1, 0, 10, 6, 2'd2, 1'b0, 4);
    drive_frame(1, 0, 10, 6, 6, 2'd2, 1'b0, 1'b0, fw);
    src_idle(1, 0);
    wait_cycles(6);
    chk("t4_err_pulses", 64'(err_cnt[1]), 64'(1));
    chk("t4_done_pulses", 64'(done_cnt[1]), 64'(1));
    chk("t4_q_empty", 64'(qsize(2)), 64'(0));
    push_frame(1, 1, 11, 4, 2'd1, 1'b0, 4);
    drive_frame(1, 1, 11, 4, 4, 2'd1, 1'b0, 1'b0, fw);
    src_idle(1, 1);
    wait_cycles(6);
    chk("t4_exact_max_no_err", 64'(err_cnt[1]), 64'(1));
    chk("t4_exact_max_done", 64'(done_cnt[1]), 64'(2));
    chk("t4_exact_q_empty", 64'(qsize(3)), 64'(0));

    // T5: tready toggling and source bubbles, tuser forwarded
    done_cnt[0] = 0;
    push_frame(0, 1, 5, 7, 2'd0, 1'b1, 384);
    begin
      bit t5_done;
      t5_done = 1'b0;
      fork
        begin
          drive_frame(0, 1, 5, 7, 7, 2'd0, 1'b1, 1'b1, fw);
          src_idle(0, 1);
          t5_done = 1'b1;
        end
        begin
          while (!t5_done) begin
            mr[0] = ~mr[0];
            @(posedge clk); #1;
          end
          mr[0] = 1'b1;
        end
      join
    end
    wait_cycles(6);
    chk("t5_done_cnt", 64'(done_cnt[0]), 64'(1));
    chk("t5_q_empty", 64'(qsize(1)), 64'(0));
    chk("t5_no_err", 64'(err_cnt[0]), 64'(0));

    // T6: reset while word 2 of 5 is presented, then no grant with cfg_en=0
    done_cnt[0] = 0;
    for (int w = 0; w < 2; w++) begin
      e = {mk_data(0, 0, 6, w), 2'd3, 1'b0, 1'b0};
      push_word(0, e);
    end
    drive_frame(0, 0, 6, 5, 2, 2'd3, 1'b0, 1'b0, fw);
    sd[0][0]  = mk_data(0, 0, 6, 2);
    sl[0][0]  = 1'b0;
    sv[0][0]  = 1'b1;
    rst       = 1'b1;
    cfg_en[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", 64'(busy[0]), 64'(0));
    chk("t6_s0_tready", 64'(sr[0][0]), 64'(0));
    chk("t6_s1_tready", 64'(sr[0][1]), 64'(0));
    chk("t6_m_tvalid", 64'(mv[0]), 64'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_no_grant_busy", 64'(busy[0]), 64'(0));
      chk("t6_no_grant_tready", 64'(sr[0][0]), 64'(0));
    end
    @(posedge clk); #1;
    src_idle(0, 0);
    chk("t6_no_tlast", 64'(done_cnt[0]), 64'(0));
    chk("t6_q_empty", 64'(qsize(0)), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
